edge_event_arbiter: RTL and testbench

- Multi-channel negative-edge event collector and scheduler.
- NUM_CH independent level inputs are each synchronised and falling-edge detected. Each detected edge is latched as a sticky pending request.
- Pending requests are granted round-robin onto one registered event port with a valid/ready handshake.
- Sits between raw strobe/handshake lines and a single event consumer (interrupt or status logic). Edges arriving faster than the consumer drains them are counted as drops.

---
 rtl/edge_arb_pkg.sv | 40 ++++
 rtl/neg_edge_sync_cell.sv | 33 +++
 rtl/edge_event_arbiter.sv | 121 ++++++++++++
 tb/tb_edge_event_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and helpers for the edge event arbiter.
package edge_arb_pkg;

    localparam int unsigned NUM_CH_MAX      = 16;
    localparam int unsigned ID_MAX_W        = 4;
    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [ID_MAX_W-1:0] idx;
    } rr_grant_t;

    // First set request strictly after ptr, wrapping within num_ch channels.
    function automatic rr_grant_t next_rr_grant(
        input logic [NUM_CH_MAX-1:0] req,
        input logic [ID_MAX_W-1:0]   ptr,
        input int unsigned           num_ch
    );
        rr_grant_t           g;
        logic [ID_MAX_W:0]   cand;
        g = '0;
        for (int unsigned off = 1; off <= NUM_CH_MAX; off++) begin
            cand = (ID_MAX_W+1)'(ptr) + (ID_MAX_W+1)'(off);
            if (cand >= (ID_MAX_W+1)'(num_ch)) begin
                cand = cand - (ID_MAX_W+1)'(num_ch);
            end
            if (!g.found && (off <= num_ch) && req[cand[ID_MAX_W-1:0]] && !cand[ID_MAX_W]) begin
                g.found = 1'b1;
                g.idx   = cand[ID_MAX_W-1:0];
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/neg_edge_sync_cell.sv
// Per-channel synchroniser with falling-edge detect and enable gate.
module neg_edge_sync_cell
    import edge_arb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    input  logic i_en,
    output logic o_fall_c
);

    localparam int unsigned STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the async input through the synchroniser; prev follows sync even when disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_sig};
            r_prev <= r_sync[STAGES-1];
        end
    end

    // Resetting to 0 means a high input after reset looks like a rise, which is ignored.
    assign o_fall_c = r_prev & ~r_sync[STAGES-1] & i_en;

endmodule

// File: rtl/edge_event_arbiter.sv
// Collects falling edges on NUM_CH inputs and presents them round-robin on one event port.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH      = 4,
    parameter  int unsigned SYNC_STAGES = 2,
    parameter  int unsigned DROP_W      = 8,
    localparam int unsigned ID_W        = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] sig_in,
    input  logic [NUM_CH-1:0] ch_en,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [ID_W-1:0]   evt_id,
    output logic [NUM_CH-1:0] pending,
    output logic [DROP_W-1:0] drop_cnt,
    input  logic              drop_clr
);

    localparam int unsigned POP_W = $clog2(NUM_CH + 1);
    localparam int unsigned SUM_W = DROP_W + POP_W;
    localparam logic [SUM_W-1:0] DROP_SAT = SUM_W'({DROP_W{1'b1}});

    logic [NUM_CH-1:0] w_fall;
    logic [NUM_CH-1:0] w_grant_oh;
    logic [NUM_CH-1:0] w_drop;
    logic [POP_W-1:0]  w_drop_pop;
    logic [SUM_W-1:0]  w_drop_sum;
    logic              w_load;
    logic              w_take;
    rr_grant_t         w_grant;

    logic [NUM_CH-1:0] r_pending;
    arb_state_t        r_state;
    logic              r_evt_valid;
    logic [ID_W-1:0]   r_evt_id;
    logic [ID_W-1:0]   r_ptr;
    logic [DROP_W-1:0] r_drop_cnt;

    // One synchroniser / edge detector per channel.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        neg_edge_sync_cell #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_sig    (sig_in[i]),
            .i_en     (ch_en[i]),
            .o_fall_c (w_fall[i])
        );
    end

    // Grant selection from registered pending bits; disabled channels are never granted.
    always_comb begin
        w_load     = (r_state == EMPTY) || evt_ready;
        w_grant    = next_rr_grant(NUM_CH_MAX'(r_pending & ch_en), ID_MAX_W'(r_ptr), NUM_CH);
        w_take     = w_load & w_grant.found;
        w_grant_oh = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_grant_oh[i] = w_take && (w_grant.idx == ID_MAX_W'(i));
        end
    end

    // A fall is lost only if the channel is already pending and not being granted this cycle.
    always_comb begin
        w_drop     = w_fall & r_pending & ~w_grant_oh;
        w_drop_pop = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            w_drop_pop = w_drop_pop + POP_W'(w_drop[i]);
        end
        w_drop_sum = (drop_clr ? '0 : SUM_W'(r_drop_cnt)) + SUM_W'(w_drop_pop);
    end

    // Sticky pending flags: a new fall wins over a same-cycle grant; disable clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= ch_en & (w_fall | (r_pending & ~w_grant_oh));
        end
    end

    // Output slot FSM: load a new event whenever the slot is empty or being accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_evt_valid <= 1'b0;
            r_evt_id    <= '0;
            r_ptr       <= ID_W'(NUM_CH - 1);
        end else if (w_load) begin
            if (w_grant.found) begin
                r_state     <= HOLD;
                r_evt_valid <= 1'b1;
                r_evt_id    <= ID_W'(w_grant.idx);
                r_ptr       <= ID_W'(w_grant.idx);
            end else begin
                r_state     <= EMPTY;
                r_evt_valid <= 1'b0;
            end
        end
    end

    // Saturating drop counter; clear takes effect before this cycle's drops are added.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop_sum > DROP_SAT) begin
            r_drop_cnt <= DROP_W'(DROP_SAT);
        end else begin
            r_drop_cnt <= DROP_W'(w_drop_sum);
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_id    = r_evt_id;
    assign pending   = r_pending;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scenario bench for edge_event_arbiter with an accepted-event scoreboard.
module tb_edge_event_arbiter;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
    localparam int DROP_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] sig_in;
    logic [NUM_CH-1:0] ch_en;
    logic              evt_ready;
    logic              drop_clr;
    logic              evt_valid;
    logic [ID_W-1:0]   evt_id;
    logic [NUM_CH-1:0] pending;
    logic [DROP_W-1:0] drop_cnt;

    int n_pass   = 0;
    int n_total  = 0;
    int n_events = 0;
    int sb_q[$];

    edge_event_arbiter #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (2),
        .DROP_W      (DROP_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .ch_en     (ch_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .drop_cnt  (drop_cnt),
        .drop_clr  (drop_clr)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted event must match the oldest expected id.
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            int exp_id;
            n_events++;
            n_total++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got id %0d, expected no event", evt_id);
            end else begin
                exp_id = sb_q.pop_front();
                if (int'(evt_id) !== exp_id) $display("FAIL sb_id: got %0d, expected %0d", evt_id, exp_id);
                else n_pass++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (evt_valid) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
    endtask

    task automatic test_reset();
        bit ok;
        int ev0;
        rst_n = 1'b0; sig_in = '1; ch_en = '1; evt_ready = 1'b0; drop_clr = 1'b0;
        #3;
        n_total++;
        if ({evt_valid, evt_id, pending, drop_cnt} !== '0) $display("FAIL reset_init: got %b, expected 0", {evt_valid, evt_id, pending, drop_cnt});
        else n_pass++;
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        sig_in[2] = 1'b0;
        wait_valid(ok);
        n_total++;
        if (!ok || evt_id !== 2'd2) $display("FAIL reset_hold: got valid %0b id %0d, expected valid 1 id 2", ok, evt_id);
        else n_pass++;
        cyc(1);
        rst_n = 1'b0;
        #2;
        n_total++;
        if ({evt_valid, evt_id, pending, drop_cnt} !== '0) $display("FAIL reset_async: got %b, expected 0", {evt_valid, evt_id, pending, drop_cnt});
        else n_pass++;
        cyc(2);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        ev0 = n_events;
        cyc(10);
        n_total++;
        if (n_events !== ev0 || evt_valid !== 1'b0) $display("FAIL reset_quiet: got %0d events, expected 0", n_events - ev0);
        else n_pass++;
        sig_in[2] = 1'b1;
        cyc(5);
    endtask

    task automatic test_round_robin();
        bit ok;
        evt_ready = 1'b1;
        sb_q.push_back(0); sb_q.push_back(1); sb_q.push_back(3);
        sig_in[0] = 1'b0; sig_in[1] = 1'b0; sig_in[3] = 1'b0;
        wait_valid(ok);
        n_total++;
        if (!ok || evt_id !== 2'd0) $display("FAIL rr_first: got valid %0b id %0d, expected id 0", ok, evt_id);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1) $display("FAIL rr_second: got valid %0b id %0d, expected id 1", evt_valid, evt_id);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) $display("FAIL rr_third: got valid %0b id %0d, expected id 3", evt_valid, evt_id);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL rr_drain: got valid %0b pending %b, expected 0 0000", evt_valid, pending);
        else n_pass++;
        sig_in = '1;
        cyc(4);
        sb_q.push_back(0); sb_q.push_back(3);
        sig_in[0] = 1'b0; sig_in[3] = 1'b0;
        wait_valid(ok);
        n_total++;
        if (!ok || evt_id !== 2'd0) $display("FAIL rr_pair_first: got valid %0b id %0d, expected id 0", ok, evt_id);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) $display("FAIL rr_pair_second: got valid %0b id %0d, expected id 3", evt_valid, evt_id);
        else n_pass++;
        sig_in = '1;
        cyc(4);
    endtask

    task automatic test_single_edge();
        int ev0;
        evt_ready = 1'b1;
        sb_q.push_back(2);
        sig_in[2] = 1'b0;
        cyc(2);
        n_total++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL single_k1: got valid %0b pending %b, expected 0 0000", evt_valid, pending);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b0 || pending !== 4'b0100) $display("FAIL single_k2: got valid %0b pending %b, expected 0 0100", evt_valid, pending);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pending !== 4'b0000) $display("FAIL single_k3: got valid %0b id %0d pending %b, expected 1 2 0000", evt_valid, evt_id, pending);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL single_k4: got valid %0b, expected 0", evt_valid);
        else n_pass++;
        ev0 = n_events;
        sig_in[2] = 1'b1;
        cyc(8);
        n_total++;
        if (n_events !== ev0 || pending !== 4'b0000) $display("FAIL single_rise: got %0d events pending %b, expected 0 0000", n_events - ev0, pending);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        for (int p = 0; p < 3; p++) begin
            sig_in[1] = 1'b0;
            cyc(3);
            sig_in[1] = 1'b1;
            cyc(3);
        end
        cyc(3);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0010 || drop_cnt !== 8'd1)
            $display("FAIL bp_hold: got valid %0b id %0d pending %b drops %0d, expected 1 1 0010 1", evt_valid, evt_id, pending, drop_cnt);
        else n_pass++;
        sb_q.push_back(1); sb_q.push_back(1);
        evt_ready = 1'b1;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd1 || pending !== 4'b0000) $display("FAIL bp_second: got valid %0b id %0d pending %b, expected 1 1 0000", evt_valid, evt_id, pending);
        else n_pass++;
        cyc(1);
        n_total++;
        if (evt_valid !== 1'b0 || drop_cnt !== 8'd1) $display("FAIL bp_done: got valid %0b drops %0d, expected 0 1", evt_valid, drop_cnt);
        else n_pass++;
    endtask

    task automatic test_saturation();
        evt_ready = 1'b0;
        for (int p = 0; p < 302; p++) begin
            sig_in[0] = 1'b0;
            cyc(3);
            sig_in[0] = 1'b1;
            cyc(3);
        end
        cyc(3);
        n_total++;
        if (drop_cnt !== 8'd255 || evt_id !== 2'd0 || pending !== 4'b0001) $display("FAIL sat_count: got drops %0d id %0d pending %b, expected 255 0 0001", drop_cnt, evt_id, pending);
        else n_pass++;
        sig_in[0] = 1'b0;
        cyc(2);
        drop_clr = 1'b1;
        cyc(1);
        drop_clr = 1'b0;
        n_total++;
        if (drop_cnt !== 8'd1) $display("FAIL clr_with_drop: got %0d, expected 1", drop_cnt);
        else n_pass++;
        sig_in[0] = 1'b1;
        cyc(2);
        drop_clr = 1'b1;
        cyc(1);
        drop_clr = 1'b0;
        n_total++;
        if (drop_cnt !== 8'd0) $display("FAIL clr_alone: got %0d, expected 0", drop_cnt);
        else n_pass++;
        sb_q.push_back(0); sb_q.push_back(0);
        evt_ready = 1'b1;
        cyc(3);
        n_total++;
        if (evt_valid !== 1'b0 || pending !== 4'b0000) $display("FAIL sat_drain: got valid %0b pending %b, expected 0 0000", evt_valid, pending);
        else n_pass++;
    endtask

    task automatic test_enable_mask();
        bit ok;
        int ev0;
        evt_ready = 1'b0;
        sb_q.push_back(2);
        sig_in[2] = 1'b0;
        wait_valid(ok);
        n_total++;
        if (!ok || evt_id !== 2'd2) $display("FAIL en_hold: got valid %0b id %0d, expected id 2", ok, evt_id);
        else n_pass++;
        sig_in[3] = 1'b0;
        cyc(4);
        n_total++;
        if (pending !== 4'b1000) $display("FAIL en_pending: got %b, expected 1000", pending);
        else n_pass++;
        ch_en[3] = 1'b0;
        cyc(1);
        n_total++;
        if (pending !== 4'b0000 || drop_cnt !== 8'd0) $display("FAIL en_clear: got pending %b drops %0d, expected 0000 0", pending, drop_cnt);
        else n_pass++;
        sig_in[3] = 1'b1;
        cyc(4);
        sig_in[3] = 1'b0;
        cyc(5);
        n_total++;
        if (pending !== 4'b0000) $display("FAIL en_masked_fall: got %b, expected 0000", pending);
        else n_pass++;
        evt_ready = 1'b1;
        cyc(3);
        n_total++;
        if (evt_valid !== 1'b0) $display("FAIL en_drain: got valid %0b, expected 0", evt_valid);
        else n_pass++;
        ev0 = n_events;
        ch_en[3] = 1'b1;
        cyc(8);
        n_total++;
        if (n_events !== ev0 || pending !== 4'b0000) $display("FAIL en_reenable: got %0d events pending %b, expected 0 0000", n_events - ev0, pending);
        else n_pass++;
        sig_in[3] = 1'b1;
        cyc(4);
        sb_q.push_back(3);
        sig_in[3] = 1'b0;
        wait_valid(ok);
        n_total++;
        if (!ok || evt_id !== 2'd3) $display("FAIL en_new_edge: got valid %0b id %0d, expected id 3", ok, evt_id);
        else n_pass++;
        cyc(4);
        n_total++;
        if (n_events !== ev0 + 1 || evt_valid !== 1'b0) $display("FAIL en_once: got %0d events, expected 1", n_events - ev0);
        else n_pass++;
        sig_in = '1;
        cyc(4);
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_edge();
        test_backpressure();
        test_saturation();
        test_enable_mask();
        n_total++;
        if (sb_q.size() !== 0) $display("FAIL sb_leftover: got %0d outstanding, expected 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
